alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_pkg.sv | 83 ++++++++
 rtl/alu_iter_mul.sv | 59 +++++
 rtl/alu_exec_unit.sv | 161 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the EX-stage execution unit:
// ALUOp groups, funct codes, ALU control encodings and FSM states.
package alu_exec_pkg;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_MUL = 2'b11;

    localparam logic [3:0] FN_ADD   = 4'b0000;
    localparam logic [3:0] FN_SUB   = 4'b1000;
    localparam logic [3:0] FN_AND   = 4'b0111;
    localparam logic [3:0] FN_OR    = 4'b0110;
    localparam logic [3:0] FN_XOR   = 4'b0100;
    localparam logic [3:0] FN_SLL   = 4'b0001;
    localparam logic [3:0] FN_SRL   = 4'b0101;
    localparam logic [3:0] FN_SRA   = 4'b1101;
    localparam logic [3:0] FN_SLT   = 4'b0010;
    localparam logic [3:0] FN_SLTU  = 4'b0011;
    localparam logic [3:0] FN_MUL   = 4'b0000;
    localparam logic [3:0] FN_MULHU = 4'b0011;

    localparam logic [3:0] CTRL_AND     = 4'b0000;
    localparam logic [3:0] CTRL_OR      = 4'b0001;
    localparam logic [3:0] CTRL_ADD     = 4'b0010;
    localparam logic [3:0] CTRL_XOR     = 4'b0011;
    localparam logic [3:0] CTRL_SLL     = 4'b0100;
    localparam logic [3:0] CTRL_SRL     = 4'b0101;
    localparam logic [3:0] CTRL_SUB     = 4'b0110;
    localparam logic [3:0] CTRL_SLT     = 4'b0111;
    localparam logic [3:0] CTRL_SLTU    = 4'b1000;
    localparam logic [3:0] CTRL_MUL     = 4'b1001;
    localparam logic [3:0] CTRL_MULHU   = 4'b1010;
    localparam logic [3:0] CTRL_SRA     = 4'b1101;
    localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DONE    = 2'd2
    } state_t;

    // ALUOp + funct to ALU control; anything undecodable maps to CTRL_ILLEGAL
    function automatic logic [3:0] decode_ctrl(
        input logic [1:0] aluop,
        input logic [3:0] funct,
        input logic       mul_en
    );
        logic [3:0] c;
        c = CTRL_ILLEGAL;
        case (aluop)
            ALUOP_MEM: c = CTRL_ADD;
            ALUOP_BR:  c = CTRL_SUB;
            ALUOP_R: begin
                case (funct)
                    FN_ADD:  c = CTRL_ADD;
                    FN_SUB:  c = CTRL_SUB;
                    FN_AND:  c = CTRL_AND;
                    FN_OR:   c = CTRL_OR;
                    FN_XOR:  c = CTRL_XOR;
                    FN_SLL:  c = CTRL_SLL;
                    FN_SRL:  c = CTRL_SRL;
                    FN_SRA:  c = CTRL_SRA;
                    FN_SLT:  c = CTRL_SLT;
                    FN_SLTU: c = CTRL_SLTU;
                    default: c = CTRL_ILLEGAL;
                endcase
            end
            ALUOP_MUL: begin
                if (mul_en) begin
                    case (funct)
                        FN_MUL:   c = CTRL_MUL;
                        FN_MULHU: c = CTRL_MULHU;
                        default:  c = CTRL_ILLEGAL;
                    endcase
                end
            end
            default: c = CTRL_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// done pulses on the step that consumes the last bit.
module alu_iter_mul
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               flush,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;

    // Latch operands on start, then add the shifted multiplicand per set bit
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (flush) begin
            busy_q <= 1'b0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done    = busy_q && (cnt_q == LAST);
    assign product = acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: ALU-control decode, registered ALU result,
// optional iterative multiplier behind a valid/ready handshake.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_EN  = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       aluop_i,
    input  logic [3:0]       funct_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic [3:0]       ctrl_o,
    output logic             illegal_o,
    output logic             stall_o
);

    state_t state_q;
    state_t state_d;

    logic [3:0]         ctrl;
    logic               illegal;
    logic               is_mul;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic               mul_hi_q;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   mul_res;
    logic [2*WIDTH-1:0] mul_prod;
    logic signed [WIDTH-1:0] sra_res;

    // Decode the presented op into an ALU control code
    always_comb begin
        ctrl = decode_ctrl(aluop_i, funct_i, MUL_EN != 0);
    end

    assign illegal   = (ctrl == CTRL_ILLEGAL);
    assign is_mul    = (ctrl == CTRL_MUL) || (ctrl == CTRL_MULHU);
    assign ready_o   = (state_q == IDLE) && (!valid_o || ready_i);
    assign accept    = valid_i && ready_o && !flush_i && !rst_i;
    assign mul_start = accept && is_mul;
    assign stall_o   = (state_q == MUL_RUN);

    assign shamt   = src2_i[SHAMT_W-1:0];
    assign sra_res = $signed(src1_i) >>> shamt;

    // Single-cycle ALU datapath; illegal and MUL codes fall to zero
    always_comb begin
        alu_res = '0;
        unique case (ctrl)
            CTRL_ADD:  alu_res = src1_i + src2_i;
            CTRL_SUB:  alu_res = src1_i - src2_i;
            CTRL_AND:  alu_res = src1_i & src2_i;
            CTRL_OR:   alu_res = src1_i | src2_i;
            CTRL_XOR:  alu_res = src1_i ^ src2_i;
            CTRL_SLL:  alu_res = src1_i << shamt;
            CTRL_SRL:  alu_res = src1_i >> shamt;
            CTRL_SRA:  alu_res = sra_res;
            CTRL_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                  $signed(src1_i) < $signed(src2_i)};
            CTRL_SLTU: alu_res = {{(WIDTH-1){1'b0}},
                                  src1_i < src2_i};
            default:   alu_res = '0;
        endcase
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_iter_mul #(
                .WIDTH(WIDTH)
            ) u_mul (
                .clk     (clk_i),
                .rst     (rst_i),
                .start   (mul_start),
                .flush   (flush_i),
                .a       (src1_i),
                .b       (src2_i),
                .product (mul_prod),
                .done    (mul_done)
            );
        end else begin : g_nomul
            assign mul_prod = '0;
            assign mul_done = 1'b0;
        end
    endgenerate

    assign mul_res = mul_hi_q ? mul_prod[2*WIDTH-1:WIDTH]
                              : mul_prod[WIDTH-1:0];

    // Remember which half of the product the running MUL wants
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mul_hi_q <= 1'b0;
        end else if (mul_start) begin
            mul_hi_q <= (ctrl == CTRL_MULHU);
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush always returns to IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (mul_start) state_d = MUL_RUN;
            MUL_RUN: if (mul_done)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // Output register: load on DONE or single-cycle accept, clear on take
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o   <= 1'b0;
            result_o  <= '0;
            zero_o    <= 1'b0;
            ctrl_o    <= CTRL_ILLEGAL;
            illegal_o <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (state_q == DONE) begin
            valid_o   <= 1'b1;
            result_o  <= mul_res;
            zero_o    <= (mul_res == '0);
            ctrl_o    <= mul_hi_q ? CTRL_MULHU : CTRL_MUL;
            illegal_o <= 1'b0;
        end else if (accept && !is_mul) begin
            valid_o   <= 1'b1;
            result_o  <= alu_res;
            zero_o    <= (alu_res == '0);
            ctrl_o    <= ctrl;
            illegal_o <= illegal;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_i;
    logic         flush_i;
    logic         valid_i;
    logic         ready_o;
    logic [1:0]   aluop_i;
    logic [3:0]   funct_i;
    logic [W-1:0] src1_i;
    logic [W-1:0] src2_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic [3:0]   ctrl_o;
    logic         illegal_o;
    logic         stall_o;

    logic         nm_ready;
    logic         nm_valid;
    logic [W-1:0] nm_result;
    logic         nm_zero;
    logic [3:0]   nm_ctrl;
    logic         nm_illegal;
    logic         nm_stall;

    alu_exec_unit #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .aluop_i   (aluop_i),
        .funct_i   (funct_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .ctrl_o    (ctrl_o),
        .illegal_o (illegal_o),
        .stall_o   (stall_o)
    );

    alu_exec_unit #(.WIDTH(W), .MUL_EN(0)) dut_nm (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .valid_i   (valid_i),
        .ready_o   (nm_ready),
        .aluop_i   (aluop_i),
        .funct_i   (funct_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .valid_o   (nm_valid),
        .ready_i   (ready_i),
        .result_o  (nm_result),
        .zero_o    (nm_zero),
        .ctrl_o    (nm_ctrl),
        .illegal_o (nm_illegal),
        .stall_o   (nm_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit         m_init = 0;
    bit         m_v = 0;
    logic [W-1:0] m_res = '0;
    bit         m_z = 0;
    logic [3:0] m_c = 4'hF;
    bit         m_i = 0;
    int         m_left = 0;
    logic [W-1:0] p_res = '0;
    logic [3:0] p_c = 4'h0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference op semantics in plain arithmetic
    function automatic void ref_op(
        input  logic [1:0]   op,
        input  logic [3:0]   f,
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        output logic [W-1:0] r,
        output logic [3:0]   c,
        output bit           ill,
        output bit           mul
    );
        logic [63:0] p;
        int unsigned sh;
        p   = 64'(a) * 64'(b);
        sh  = b % W;
        r   = '0;
        c   = 4'hF;
        ill = 1;
        mul = 0;
        if (op == 2'b00) begin
            r = a + b; c = 4'b0010; ill = 0;
        end else if (op == 2'b01) begin
            r = a - b; c = 4'b0110; ill = 0;
        end else if (op == 2'b10) begin
            ill = 0;
            case (f)
                4'b0000: begin r = a + b; c = 4'b0010; end
                4'b1000: begin r = a - b; c = 4'b0110; end
                4'b0111: begin r = a & b; c = 4'b0000; end
                4'b0110: begin r = a | b; c = 4'b0001; end
                4'b0100: begin r = a ^ b; c = 4'b0011; end
                4'b0001: begin r = a << sh; c = 4'b0100; end
                4'b0101: begin r = a >> sh; c = 4'b0101; end
                4'b1101: begin
                    r = W'($signed(a) >>> sh); c = 4'b1101;
                end
                4'b0010: begin
                    r = ($signed(a) < $signed(b)) ? 1 : 0; c = 4'b0111;
                end
                4'b0011: begin r = (a < b) ? 1 : 0; c = 4'b1000; end
                default: ill = 1;
            endcase
        end else begin
            if (f == 4'b0000) begin
                r = p[31:0]; c = 4'b1001; ill = 0; mul = 1;
            end else if (f == 4'b0011) begin
                r = p[63:32]; c = 4'b1010; ill = 0; mul = 1;
            end
        end
    endfunction

    // One clock: drive at negedge, predict, check after posedge
    task automatic step(input logic r, input logic fl, input logic v,
                        input logic [1:0] op, input logic [3:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic rd);
        bit mrdy;
        logic [W-1:0] er;
        logic [3:0] ec;
        bit ei;
        bit im;
        @(negedge clk);
        rst_i = r; flush_i = fl; valid_i = v;
        aluop_i = op; funct_i = f;
        src1_i = a; src2_i = b; ready_i = rd;
        #1;
        mrdy = (m_left == 0) && (!m_v || rd);
        if (m_init) begin
            chk("ready", ready_o, mrdy);
            chk("stall", stall_o, m_left >= 2);
        end
        if (r) begin
            m_v = 0; m_res = '0; m_z = 0; m_c = 4'hF; m_i = 0; m_left = 0;
        end else if (fl) begin
            m_v = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_v = 1; m_res = p_res; m_z = (p_res == 0);
                m_c = p_c; m_i = 0;
            end
        end else if (v && mrdy) begin
            ref_op(op, f, a, b, er, ec, ei, im);
            if (im) begin
                m_left = W + 1; p_res = er; p_c = ec; m_v = 0;
            end else begin
                m_v = 1; m_res = er; m_z = (er == 0); m_c = ec; m_i = ei;
            end
        end else if (rd) begin
            m_v = 0;
        end
        @(posedge clk);
        #1;
        if (r) m_init = 1;
        if (m_init) begin
            chk("valid", valid_o, m_v);
            chk("result", result_o, m_res);
            if (m_v) begin
                chk("zero", zero_o, m_z);
                chk("ctrl", ctrl_o, m_c);
                chk("illegal", illegal_o, m_i);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 4'h0, 0, 0, 1);
    endtask

    task automatic mul_lat(input logic [3:0] f, input string tag);
        int lat;
        int stl;
        lat = -1;
        step(0, 0, 1, 2'b11, f, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        stl = stall_o ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            step(0, 0, 0, 2'b00, 4'h0, 0, 0, 1);
            if (stall_o) stl++;
            if (valid_o) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, lat, W + 1);
        chk({tag, "_stall"}, stl, W);
    endtask

    logic [W-1:0] held;
    logic [W-1:0] edges [5];
    logic [3:0]   rfn [10];

    initial begin
        logic [1:0] op;
        logic [3:0] f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        rfn = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
                4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011};
        rst_i = 1; flush_i = 0; valid_i = 0; aluop_i = 0; funct_i = 0;
        src1_i = 0; src2_i = 0; ready_i = 1;

        step(1, 0, 0, 2'b00, 4'h0, 0, 0, 1);
        step(1, 0, 0, 2'b00, 4'h0, 0, 0, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_zero", zero_o, 0);
        chk("rst_ctrl", ctrl_o, 4'b1111);
        chk("rst_illegal", illegal_o, 0);
        chk("rst_stall", stall_o, 0);

        // reset in the middle of a multiply
        step(0, 0, 1, 2'b11, 4'b0000, 3, 5, 1);
        idle(3);
        step(1, 0, 0, 2'b00, 4'h0, 0, 0, 1);
        chk("rmul_valid", valid_o, 0);
        chk("rmul_stall", stall_o, 0);
        chk("rmul_ctrl", ctrl_o, 4'b1111);
        idle(40);

        // R-type stream, one per cycle
        step(0, 0, 1, 2'b10, 4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1);
        chk("and", result_o, 32'h00F0_00F0);
        step(0, 0, 1, 2'b10, 4'b1000, 5, 7, 1);
        chk("sub", result_o, 32'hFFFF_FFFE);
        step(0, 0, 1, 2'b10, 4'b0010, 32'hFFFF_FFFF, 1, 1);
        chk("slt", result_o, 1);
        step(0, 0, 1, 2'b10, 4'b0011, 32'hFFFF_FFFF, 1, 1);
        chk("sltu", result_o, 0);
        chk("sltu_zero", zero_o, 1);

        // shifts use only the low shamt bits
        step(0, 0, 1, 2'b10, 4'b1101, 32'h8000_0000, 32'h21, 1);
        chk("sra", result_o, 32'hC000_0000);
        step(0, 0, 1, 2'b10, 4'b0101, 32'h8000_0000, 32'h21, 1);
        chk("srl", result_o, 32'h4000_0000);
        step(0, 0, 1, 2'b10, 4'b0001, 1, 31, 1);
        chk("sll", result_o, 32'h8000_0000);
        idle(1);

        // multi-cycle multiply latency and stall
        mul_lat(4'b0000, "mul");
        chk("mul_res", result_o, 32'h0000_0001);
        chk("mul_ctrl", ctrl_o, 4'b1001);
        mul_lat(4'b0011, "mulhu");
        chk("mulhu_res", result_o, 32'hFFFF_FFFE);
        chk("mulhu_ctrl", ctrl_o, 4'b1010);
        idle(1);

        // backpressure holds the result
        step(0, 0, 1, 2'b10, 4'b0110, 32'h1200, 32'h0034, 0);
        held = result_o;
        chk("bp_first", held, 32'h1234);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 2'b00, 4'h0, 32'd10, 32'd20, 0);
            chk("bp_hold", result_o, held);
            chk("bp_ready", ready_o, 0);
        end
        step(0, 0, 1, 2'b00, 4'h0, 32'd10, 32'd20, 1);
        chk("bp_new", result_o, 32'd30);
        idle(1);

        // flush in the middle of a multiply
        step(0, 0, 1, 2'b11, 4'b0000, 32'd1000, 32'd1000, 1);
        idle(9);
        step(0, 1, 0, 2'b00, 4'h0, 0, 0, 1);
        chk("flush_valid", valid_o, 0);
        chk("flush_stall", stall_o, 0);
        idle(40);

        // undecodable R-type funct
        step(0, 0, 1, 2'b10, 4'b1111, 32'h55, 32'hAA, 1);
        chk("ill_res", result_o, 0);
        chk("ill_flag", illegal_o, 1);
        chk("ill_zero", zero_o, 1);
        chk("ill_ctrl", ctrl_o, 4'b1111);
        idle(1);

        // MUL group is illegal without the multiplier
        step(0, 0, 1, 2'b11, 4'b0000, 32'd7, 32'd9, 1);
        chk("nm_valid", nm_valid, 1);
        chk("nm_illegal", nm_illegal, 1);
        chk("nm_res", nm_result, 0);
        chk("nm_zero", nm_zero, 1);
        chk("nm_ctrl", nm_ctrl, 4'b1111);
        chk("nm_stall", nm_stall, 0);
        idle(40);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) f = 4'($urandom);
            else if (op == 2'b11) f = ($urandom_range(0, 1) == 0) ? 4'b0000
                                                                  : 4'b0011;
            else f = rfn[$urandom_range(0, 9)];
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)]
                                            : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)]
                                            : 32'($urandom);
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 7,
                 op, f, a, b,
                 $urandom_range(0, 3) != 0);
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
